// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back controller:
//   - destination-select encodings (same encoding on ex_wsel and reg_write)
//   - FSM state encoding for wb_ctrl
//   - upper bound of the data-memory read latency and the width of the
//     latency counter that has to hold it
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam logic [1:0] WSEL_NONE = 2'b00;
    localparam logic [1:0] WSEL_RS   = 2'b01;
    localparam logic [1:0] WSEL_RT   = 2'b10;
    localparam logic [1:0] WSEL_RA   = 2'b11;

    localparam int MEM_LAT_MAX = 15;
    // Wide enough to hold MEM_LAT_MAX - 1.
    localparam int LAT_CNT_W   = 4;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_MEM_WAIT = 1'b1
    } wb_state_e;

    // True when a destination select actually names a register.
    function automatic logic wsel_writes(input logic [1:0] wsel);
        return wsel != WSEL_NONE;
    endfunction

endpackage

// File: rtl/wb_lat_cnt.sv
// ---------------------------------------------------------------------------
// wb_lat_cnt
// Loadable down-counter with a zero flag. Used by wb_ctrl to time the
// fixed-latency data-memory read.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous, active-high reset (count -> 0)
//   clr_i      in   force the count to 0 (highest priority)
//   load_i     in   load load_val_i
//   load_val_i in   value to load
//   en_i       in   decrement by one (holds at 0)
//   zero_o     out  count is 0
// ---------------------------------------------------------------------------
module wb_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wb_ctrl.sv
// ---------------------------------------------------------------------------
// wb_ctrl
// Write-back controller in front of the register file. It is the only
// driver of reg_write/write_data. ALU results are committed on the edge
// after acceptance; loads issue a one-cycle data-memory read strobe, wait
// MEM_LAT cycles in MEM_WAIT (execute stalled), then commit the read data.
//
// Handshake: a transaction transfers on a clock edge where ex_valid and
// ex_ready are both high. ex_ready depends only on state, rst and flush,
// never on ex_valid, and ex_valid may be held or dropped freely while
// ex_ready is low.
//
// Parameters:
//   DATA_W   datapath width
//   ADDR_W   data-memory word-address width
//   MEM_LAT  read latency in cycles, legal range 1..MEM_LAT_MAX (15)
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   ex_valid/ex_ready/ex_wsel/ex_is_load/ex_res/ex_addr  execute-stage input
//   flush         abort the pending load and refuse any offered work
//   mem_rd_en, mem_addr, mem_rd_data                     data-memory read
//   reg_write, write_data                                register-file write
//   dbg_state_o   current FSM state, for observation
//
// Optional build (macro WB_BYPASS_EN):
//   fwd_valid, fwd_wsel, fwd_data  mirror of the register-file write
//   ld_busy                        high while a load is in MEM_WAIT
// ---------------------------------------------------------------------------
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_wsel,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [1:0]        reg_write,
    output logic [DATA_W-1:0] write_data,
    output wb_state_e         dbg_state_o
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd_valid,
    output logic [1:0]        fwd_wsel,
    output logic [DATA_W-1:0] fwd_data,
    output logic              ld_busy
`endif
);

    // Counter starts at MEM_LAT-1 so that the zero flag is seen on the
    // MEM_LAT-th edge after acceptance, i.e. MEM_WAIT lasts MEM_LAT cycles.
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

    wb_state_e         state_q, state_d;
    logic [1:0]        reg_write_q, reg_write_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        pend_wsel_q, pend_wsel_d;

    logic accept;
    logic cnt_load, cnt_en, cnt_clr, cnt_zero;

    assign ex_ready = (state_q == WB_IDLE) & ~rst & ~flush;
    assign accept   = ex_valid & ex_ready;

    wb_lat_cnt #(
        .W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (LAT_INIT),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        reg_write_d  = WSEL_NONE;      // write is a one-cycle pulse
        write_data_d = write_data_q;
        mem_rd_en_d  = 1'b0;           // read strobe is a one-cycle pulse
        mem_addr_d   = mem_addr_q;
        pend_wsel_d  = pend_wsel_q;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_clr      = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (ex_is_load) begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = ex_addr;
                        pend_wsel_d = ex_wsel;
                        cnt_load    = 1'b1;
                        state_d     = WB_MEM_WAIT;
                    end else if (wsel_writes(ex_wsel)) begin
                        reg_write_d  = ex_wsel;
                        write_data_d = ex_res;
                    end
                end
            end
            WB_MEM_WAIT: begin
                // flush wins even on the commit edge: the read data is dropped.
                if (flush) begin
                    cnt_clr = 1'b1;
                    state_d = WB_IDLE;
                end else if (cnt_zero) begin
                    reg_write_d = pend_wsel_q;
                    if (wsel_writes(pend_wsel_q)) begin
                        write_data_d = mem_rd_data;
                    end
                    state_d = WB_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WB_IDLE;
            reg_write_q  <= WSEL_NONE;
            write_data_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            pend_wsel_q  <= WSEL_NONE;
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            write_data_q <= write_data_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            pend_wsel_q  <= pend_wsel_d;
        end
    end

    assign reg_write   = reg_write_q;
    assign write_data  = write_data_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign dbg_state_o = state_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid = wsel_writes(reg_write_q);
    assign fwd_wsel  = reg_write_q;
    assign fwd_data  = write_data_q;
    assign ld_busy   = (state_q == WB_MEM_WAIT);
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_ctrl
// Self-checking bench for wb_ctrl. A behavioural model tracks how many wait
// cycles a load still has and which write the register file must see after
// each edge; a data-memory model returns valid data only in the cycle the
// controller is due to capture it. Build with WB_BYPASS_EN to also cover the
// forwarding and load-busy outputs.
// ---------------------------------------------------------------------------
module tb_wb_ctrl;
    import wb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int MEM_LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              ex_valid;
    logic              ex_ready;
    logic [1:0]        ex_wsel;
    logic              ex_is_load;
    logic [DATA_W-1:0] ex_res;
    logic [ADDR_W-1:0] ex_addr;
    logic              flush;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [1:0]        reg_write;
    logic [DATA_W-1:0] write_data;
    wb_state_e         dbg_state;
`ifdef WB_BYPASS_EN
    logic              fwd_valid;
    logic [1:0]        fwd_wsel;
    logic [DATA_W-1:0] fwd_data;
    logic              ld_busy;
`endif

    wb_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_wsel     (ex_wsel),
        .ex_is_load  (ex_is_load),
        .ex_res      (ex_res),
        .ex_addr     (ex_addr),
        .flush       (flush),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .reg_write   (reg_write),
        .write_data  (write_data),
        .dbg_state_o (dbg_state)
`ifdef WB_BYPASS_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_wsel    (fwd_wsel),
        .fwd_data    (fwd_data),
        .ld_busy     (ld_busy)
`endif
    );

    // ---------------- data-memory model ----------------
    // Data is valid only in the cycle ending at the edge MEM_LAT edges after
    // the edge that accepted the load; any other cycle carries junk.
    logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
    logic              rd_pend;
    int                rd_age;
    logic [ADDR_W-1:0] rd_addr_l;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr_now;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_age    <= 0;
            rd_addr_l <= '0;
        end else if (mem_rd_en) begin
            rd_pend   <= 1'b1;
            rd_age    <= 1;
            rd_addr_l <= mem_addr;
        end else if (rd_pend) begin
            rd_age <= rd_age + 1;
        end
    end

    always_comb begin
        rd_addr_now = mem_rd_en ? mem_addr : rd_addr_l;
        rd_valid    = mem_rd_en ? (MEM_LAT == 1) : (rd_pend && (rd_age == MEM_LAT - 1));
        mem_rd_data = rd_valid ? mem_arr[rd_addr_now] : (32'hBADD_A7A0 ^ {22'd0, rd_addr_now});
    end

    // ---------------- scoreboard / model state ----------------
    int                checks = 0;
    int                errors = 0;
    int                busy_left;      // remaining MEM_WAIT cycles of the pending load
    logic [1:0]        pend_wsel;
    logic [ADDR_W-1:0] pend_addr;
    logic [1:0]        exp_rw;
    logic [DATA_W-1:0] exp_wd;
    logic              exp_rden;
    logic [ADDR_W-1:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_left = 0;
        pend_wsel = WSEL_NONE;
        pend_addr = '0;
        exp_rw    = WSEL_NONE;
        exp_wd    = '0;
        exp_rden  = 1'b0;
        exp_addr  = '0;
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        ex_wsel    = WSEL_NONE;
        ex_is_load = 1'b0;
        ex_res     = '0;
        ex_addr    = '0;
        flush      = 1'b0;
    endtask

    task automatic check_outputs();
        chk("reg_write", 32'(reg_write), 32'(exp_rw));
        if (exp_rw != WSEL_NONE) chk("write_data", write_data, exp_wd);
        chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rden));
        if (exp_rden) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("state", 32'(dbg_state), 32'((busy_left > 0) ? WB_MEM_WAIT : WB_IDLE));
`ifdef WB_BYPASS_EN
        chk("ld_busy", 32'(ld_busy), 32'(busy_left > 0));
        chk("fwd_valid", 32'(fwd_valid), 32'(exp_rw != WSEL_NONE));
        chk("fwd_wsel", 32'(fwd_wsel), 32'(exp_rw));
        if (exp_rw != WSEL_NONE) chk("fwd_data", fwd_data, exp_wd);
`endif
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic v, input logic [1:0] w, input logic ld,
                        input logic [DATA_W-1:0] res, input logic [ADDR_W-1:0] a,
                        input logic fl);
        logic exp_ready;
        logic acc;
        @(negedge clk);
        ex_valid   = v;
        ex_wsel    = w;
        ex_is_load = ld;
        ex_res     = res;
        ex_addr    = a;
        flush      = fl;
        #1;
        exp_ready = (busy_left == 0) && !fl;
        chk("ex_ready", 32'(ex_ready), 32'(exp_ready));
        acc = v && exp_ready;

        exp_rden = 1'b0;
        exp_rw   = WSEL_NONE;
        if (busy_left > 0) begin
            if (fl) begin
                busy_left = 0;
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    exp_rw = pend_wsel;
                    if (pend_wsel != WSEL_NONE) exp_wd = mem_arr[pend_addr];
                end
            end
        end else if (acc) begin
            if (ld) begin
                busy_left = MEM_LAT;
                exp_rden  = 1'b1;
                exp_addr  = a;
                pend_wsel = w;
                pend_addr = a;
            end else begin
                exp_rw = w;
                if (w != WSEL_NONE) exp_wd = res;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, WSEL_NONE, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ex_ready"},   32'(ex_ready),   32'd0);
        chk({tag, "_reg_write"},  32'(reg_write),  32'd0);
        chk({tag, "_write_data"}, write_data,      32'd0);
        chk({tag, "_mem_rd_en"},  32'(mem_rd_en),  32'd0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
`ifdef WB_BYPASS_EN
        chk({tag, "_fwd_valid"},  32'(fwd_valid),  32'd0);
        chk({tag, "_ld_busy"},    32'(ld_busy),    32'd0);
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DATA_W-1:0] r;
        for (int i = 0; i < (1 << ADDR_W); i++) mem_arr[i] = $urandom;
        mem_arr[10'h12A] = 32'h0000_CAFE;
        idle_inputs();
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write, ex_ready stays high
        step(1'b1, WSEL_RS, 1'b0, 32'hDEAD_BEEF, '0, 1'b0);
        idle(1);

        // Back-to-back ALU retirements: 10, 11, 00
        step(1'b1, WSEL_RT,   1'b0, $urandom, '0, 1'b0);
        step(1'b1, WSEL_RA,   1'b0, $urandom, '0, 1'b0);
        step(1'b1, WSEL_NONE, 1'b0, $urandom, '0, 1'b0);
        idle(1);

        // Load to rt from 0x12A; offers during the wait must be refused
        step(1'b1, WSEL_RT, 1'b0 | 1'b1, $urandom, 10'h12A, 1'b0);
        step(1'b1, WSEL_RS, 1'b0, $urandom, '0, 1'b0);
        step(1'b1, WSEL_RS, 1'b0, $urandom, '0, 1'b0);
        idle(2);

        // Load, flush on the commit cycle, then an ALU op commits normally
        step(1'b1, WSEL_RA, 1'b1, '0, 10'($urandom), 1'b0);
        idle(MEM_LAT - 1);
        step(1'b0, WSEL_NONE, 1'b0, '0, '0, 1'b1);
        step(1'b1, WSEL_RS, 1'b0, $urandom, '0, 1'b0);
        idle(1);

        // Flush in the first wait cycle
        step(1'b1, WSEL_RT, 1'b1, '0, 10'($urandom), 1'b0);
        step(1'b0, WSEL_NONE, 1'b0, '0, '0, 1'b1);
        idle(MEM_LAT + 1);

        // Flush in IDLE refuses the offered transaction
        step(1'b1, WSEL_RA, 1'b0, $urandom, '0, 1'b1);
        step(1'b1, WSEL_RA, 1'b1, '0, 10'h12A, 1'b1);
        idle(1);

        // Load with no destination: read issued and waited out, no write
        step(1'b1, WSEL_NONE, 1'b1, '0, 10'($urandom), 1'b0);
        idle(MEM_LAT + 1);

        // Load immediately followed by another load after commit
        step(1'b1, WSEL_RS, 1'b1, '0, 10'($urandom), 1'b0);
        idle(MEM_LAT);
        step(1'b1, WSEL_RA, 1'b1, '0, 10'($urandom), 1'b0);
        idle(MEM_LAT + 1);

        // Asynchronous reset while in MEM_WAIT
        step(1'b1, WSEL_RT, 1'b1, '0, 10'h3FF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        idle(MEM_LAT + 2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            step(r[1:0] != 2'b00, r[3:2], r[6:4] < 3'd3, $urandom,
                 10'($urandom), r[9:7] == 3'd0);
        end
        idle(MEM_LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
